lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Parametrised load/store unit; successor of the single-cycle DPI-backed LSU.
- Sits between EXU and a generic memory/bus port.
- Accepts one load or store per transaction over valid/ready, aligns store data and byte masks to bus lanes, and extracts and extends load data.
- Reports misalignment, bus errors and timeouts instead of silently returning data.

Parameters:
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: bus data width; legal values are 32 or 64.
- TIMEOUT, 256: maximum cycles spent in REQ+RESP before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-low (state is reset on a posedge clk while rst==0).
- in_valid  in  1  request valid from EXU.
- in_ready  out  1  LSU can accept a request.
- in_ren  in  1  load.
- in_wen  in  1  store.
- in_addr  in  ADDR_WIDTH  byte address.
- in_wdata  in  DATA_WIDTH  store data, right-aligned.
- in_ctl  in  3  [1:0] size (00 b, 01 h, 10 w, 11 d); [2] unsigned load.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- out_err  out  2  00 ok, 01 misaligned/illegal size, 10 bus error, 11 timeout.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_WIDTH  in_addr with low log2(DATA_WIDTH/8) bits cleared.
- mem_req_wen  out  1  write request.
- mem_req_wdata  out  DATA_WIDTH  lane-shifted store data.
- mem_req_wmask  out  DATA_WIDTH/8  byte-enable mask.
- mem_resp_valid  in  1  response valid.
- mem_resp_ready  out  1  LSU accepts the response.
- mem_resp_rdata  in  DATA_WIDTH  raw bus word.
- mem_resp_err  in  1  bus error.

Behaviour:
- States: IDLE, REQ, RESP, DONE. Reset forces IDLE from any state.
  - Any pending memory request is abandoned on reset; no memory handshake is owed.
  - Registered outputs are reset to 0.
- Output values by state:
  - IDLE: in_ready=1, mem_resp_ready=1 (drains stray responses silently), all other outputs 0.
  - REQ: mem_req_valid=1; addr, wen, wdata and wmask are registered and held stable until mem_req_ready.
  - RESP: mem_resp_ready=1.
  - DONE: out_valid=1; out_rdata and out_err are held until out_ready.
- Request acceptance: a request is accepted on in_valid & in_ready; its fields are latched.
- Decode at acceptance (off = in_addr low bits within the bus word):
  - Size bytes = 1 << size.
  - Size 11 with DATA_WIDTH=32 is illegal: go to DONE with err 01.
  - off not a multiple of size bytes is misaligned: go to DONE with err 01. No memory request is issued in either error case.
  - ren=0 and wen=0: no-op, go to DONE with err 00 and rdata 0.
  - ren=1 and wen=1: treated as a store.
  - Otherwise go to REQ.
- Store formatting:
  - wmask = ((1<<sizebytes)-1) << off.
  - wdata = in_wdata << (8*off); bytes outside the mask are don't-care but driven 0.
- Load request: mem_req_wmask=0.
- REQ to RESP: on mem_req_valid & mem_req_ready.
- RESP to DONE: on mem_resp_valid.
  - If mem_resp_err: err 10, rdata 0.
  - Else shift raw data right by 8*off, take sizebytes bytes, then zero-extend if ctl[2] else sign-extend to DATA_WIDTH.
  - Store responses return rdata 0, err 00.
- Timeout:
  - The counter clears on acceptance and increments each cycle in REQ or RESP.
  - When count==TIMEOUT-1 with no completing handshake that cycle, go to DONE with err 11.
  - A handshake completing in that same cycle takes priority over the timeout.
  - A late response after timeout is absorbed in IDLE and never surfaces.
- DONE to IDLE: on out_ready. The next request cannot be accepted in the same cycle; throughput is at most one transaction per 4 cycles.
- Latency:
  - Request accepted at cycle N. If memory is ready immediately and the response arrives at N+2, out_valid is asserted at N+3.
  - Error and no-op cases assert out_valid at N+1.
- Backpressure: all outputs are stable while a valid is asserted and its ready is low.

Test Plan:
- Load sign extension: DATA_WIDTH=32, lb addr 0x80000003, ctl=000, memory returns 0x80FF1234.
  - mem_req_addr=0x80000000, wmask=0.
  - out_rdata=0xFFFFFF80, err 00.
  - Repeat with ctl=100: out_rdata=0x00000080.
- Store lane shift: sh addr 0x80000002, wdata 0x0000ABCD.
  - mem_req_wmask=4'b1100, mem_req_wdata=0xABCD0000.
  - Hold mem_req_ready=0 for 5 cycles: request fields stay stable throughout.
- Misaligned: lw addr 0x80000001.
  - No mem_req_valid.
  - out_valid one cycle after acceptance, err 01.
  - Same result for size 11 at DATA_WIDTH=32.
- Bus error: load, mem_resp_err=1.
  - err 10, out_rdata 0.
  - out_ready held 0 for 3 cycles: out_valid and err held, in_ready stays 0.
- Timeout: TIMEOUT=8, mem_req_ready stuck 0.
  - err 11 after 8 cycles in REQ.
  - A later stray mem_resp_valid in IDLE is absorbed; the next load completes normally.
- 64-bit and reset: DATA_WIDTH=64, ld addr 0x10 returns 64-bit word.
  - out_rdata equals the full returned word.
  - rst=0 asserted while in RESP: the next cycle is IDLE with all outputs 0.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit between EXU and a generic memory port; one transaction in flight, out_valid
// at N+3 for a zero-wait memory and N+1 for decode errors; all outputs hold while valid && !ready.
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_ren,
  input  logic                    in_wen,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  input  logic [2:0]              in_ctl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_rdata,
  output logic [1:0]              out_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_resp_rdata,
  input  logic                    mem_resp_err
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT < 2) ? 2 : $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TLIM = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [1:0] ERR_OK = 2'b00, ERR_ALIGN = 2'b01, ERR_BUS = 2'b10, ERR_TMO = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [NB-1:0]         wmask;
  } memreq_t;

  typedef struct packed {
    logic [OFFW-1:0] off;
    logic [1:0]      size;
    logic            uns;
  } ldctl_t;

  state_t                state_q, state_d;
  memreq_t               req_q, dec_req;
  ldctl_t                ld_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            err_q;

  int                    in_nbytes;
  logic [OFFW-1:0]       in_off;
  logic                  dec_bad, dec_noop;
  logic [NB-1:0]         size_mask;
  logic [DATA_WIDTH-1:0] byte_bits;

  int                    ld_nbits;
  logic [DATA_WIDTH-1:0] ld_shift, ld_data;
  logic                  ld_sign, ld_fill;
  logic                  tmo;

  assign tmo = (TIMEOUT != 0) && (cnt_q >= TLIM);

  // Request decode and store lane formatting, evaluated on the incoming fields.
  always_comb begin
    in_nbytes = 1 << in_ctl[1:0];
    in_off    = in_addr[OFFW-1:0];
    dec_bad   = ((in_ctl[1:0] == 2'b11) && (DATA_WIDTH == 32)) ||
                ((in_off & OFFW'(in_nbytes - 1)) != '0);
    dec_noop  = !in_ren && !in_wen;
    for (int i = 0; i < NB; i++) size_mask[i] = (i < in_nbytes);
    dec_req.addr  = {in_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    dec_req.wen   = in_wen;
    dec_req.wmask = in_wen ? (size_mask << in_off) : '0;
    for (int i = 0; i < NB; i++) byte_bits[8*i +: 8] = {8{dec_req.wmask[i]}};
    dec_req.wdata = (in_wdata << {in_off, 3'b000}) & byte_bits;
  end

  always_comb begin
    ld_nbits = 8 << ld_q.size;
    ld_shift = mem_resp_rdata >> {ld_q.off, 3'b000};
    case (ld_q.size)
      2'd0:    ld_sign = ld_shift[7];
      2'd1:    ld_sign = ld_shift[15];
      2'd2:    ld_sign = ld_shift[31];
      default: ld_sign = ld_shift[DATA_WIDTH-1];
    endcase
    ld_fill = ld_sign & ~ld_q.uns;
    for (int i = 0; i < DATA_WIDTH; i++) ld_data[i] = (i < ld_nbits) ? ld_shift[i] : ld_fill;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // A handshake in the same cycle as the timeout limit wins over the abort.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = (dec_bad || dec_noop) ? DONE : REQ;
      REQ:  if (mem_req_ready) state_d = RESP;
            else if (tmo)      state_d = DONE;
      RESP: if (mem_resp_valid || tmo) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q   <= '0;
      ld_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          req_q   <= dec_req;
          ld_q    <= '{off: in_off, size: in_ctl[1:0], uns: in_ctl[2]};
          cnt_q   <= '0;
          rdata_q <= '0;
          err_q   <= dec_bad ? ERR_ALIGN : ERR_OK;
        end
        REQ: begin
          cnt_q <= cnt_q + CW'(1);
          if (!mem_req_ready && tmo) err_q <= ERR_TMO;
        end
        RESP: begin
          cnt_q <= cnt_q + CW'(1);
          if (mem_resp_valid) begin
            err_q   <= mem_resp_err ? ERR_BUS : ERR_OK;
            rdata_q <= (mem_resp_err || req_q.wen) ? '0 : ld_data;
          end else if (tmo) begin
            err_q <= ERR_TMO;
          end
        end
        DONE: ;
      endcase
    end
  end

  always_comb begin
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_rdata      = '0;
    out_err        = '0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    mem_req_wen    = 1'b0;
    mem_req_wdata  = '0;
    mem_req_wmask  = '0;
    mem_resp_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready       = 1'b1;
        mem_resp_ready = 1'b1;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = req_q.addr;
        mem_req_wen   = req_q.wen;
        mem_req_wdata = req_q.wdata;
        mem_req_wmask = req_q.wmask;
      end
      RESP: mem_resp_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        out_rdata = rdata_q;
        out_err   = err_q;
      end
    endcase
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: 32-bit and 64-bit instances share stimulus, a per-cycle phase model
// derived from the transaction timeline drives the expectations checked on every falling edge.
module tb_lsu_mem_port;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst, sel64;
  logic        in_valid, in_ren, in_wen, out_ready, mem_req_ready, mem_resp_valid, mem_resp_err;
  logic [31:0] in_addr;
  logic [63:0] in_wdata, mem_resp_rdata;
  logic [2:0]  in_ctl;

  logic        a_in_ready, a_out_valid, a_mem_req_valid, a_mem_req_wen, a_mem_resp_ready;
  logic [31:0] a_out_rdata, a_mem_req_addr, a_mem_req_wdata;
  logic [1:0]  a_out_err;
  logic [3:0]  a_mem_req_wmask;
  logic        b_in_ready, b_out_valid, b_mem_req_valid, b_mem_req_wen, b_mem_resp_ready;
  logic [63:0] b_out_rdata, b_mem_req_wdata;
  logic [31:0] b_mem_req_addr;
  logic [1:0]  b_out_err;
  logic [7:0]  b_mem_req_wmask;

  logic        in_ready, out_valid, mem_req_valid, mem_req_wen, mem_resp_ready;
  logic [63:0] out_rdata, mem_req_wdata;
  logic [31:0] mem_req_addr;
  logic [1:0]  out_err;
  logic [7:0]  mem_req_wmask;

  always #5 clk = ~clk;

  lsu_mem_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel64), .in_ready(a_in_ready),
    .in_ren(in_ren), .in_wen(in_wen), .in_addr(in_addr), .in_wdata(in_wdata[31:0]), .in_ctl(in_ctl),
    .out_valid(a_out_valid), .out_ready(out_ready & ~sel64), .out_rdata(a_out_rdata), .out_err(a_out_err),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready & ~sel64), .mem_req_addr(a_mem_req_addr),
    .mem_req_wen(a_mem_req_wen), .mem_req_wdata(a_mem_req_wdata), .mem_req_wmask(a_mem_req_wmask),
    .mem_resp_valid(mem_resp_valid & ~sel64), .mem_resp_ready(a_mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata[31:0]), .mem_resp_err(mem_resp_err));

  lsu_mem_port #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(TMO)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel64), .in_ready(b_in_ready),
    .in_ren(in_ren), .in_wen(in_wen), .in_addr(in_addr), .in_wdata(in_wdata), .in_ctl(in_ctl),
    .out_valid(b_out_valid), .out_ready(out_ready & sel64), .out_rdata(b_out_rdata), .out_err(b_out_err),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready & sel64), .mem_req_addr(b_mem_req_addr),
    .mem_req_wen(b_mem_req_wen), .mem_req_wdata(b_mem_req_wdata), .mem_req_wmask(b_mem_req_wmask),
    .mem_resp_valid(mem_resp_valid & sel64), .mem_resp_ready(b_mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err));

  always_comb begin
    in_ready       = sel64 ? b_in_ready       : a_in_ready;
    out_valid      = sel64 ? b_out_valid      : a_out_valid;
    out_rdata      = sel64 ? b_out_rdata      : {32'd0, a_out_rdata};
    out_err        = sel64 ? b_out_err        : a_out_err;
    mem_req_valid  = sel64 ? b_mem_req_valid  : a_mem_req_valid;
    mem_req_addr   = sel64 ? b_mem_req_addr   : a_mem_req_addr;
    mem_req_wen    = sel64 ? b_mem_req_wen    : a_mem_req_wen;
    mem_req_wdata  = sel64 ? b_mem_req_wdata  : {32'd0, a_mem_req_wdata};
    mem_req_wmask  = sel64 ? b_mem_req_wmask  : {4'd0, a_mem_req_wmask};
    mem_resp_ready = sel64 ? b_mem_resp_ready : a_mem_resp_ready;
  end

  int checks = 0, failures = 0;

  // Expected per-cycle behaviour, written by the stimulus from the transaction model.
  bit          mon_en = 0, exp_idle = 1, exp_rr = 1, exp_req_ok = 0, exp_out_on = 0;
  logic [31:0] exp_addr;
  logic        exp_wen;
  logic [63:0] exp_wdata, exp_rdata;
  logic [7:0]  exp_wmask;
  logic [1:0]  exp_err;
  logic [63:0] obs_rdata, obs_wdata;
  logic [31:0] obs_addr;
  logic [7:0]  obs_wmask;
  logic [1:0]  obs_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", in_ready, exp_idle);
      chk("mem_resp_ready", mem_resp_ready, exp_rr);
      chk("mem_req_valid", mem_req_valid, exp_req_ok);
      chk("out_valid", out_valid, exp_out_on);
      if (exp_idle)
        chk("idle_zero", |{out_rdata, out_err, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask}, 0);
      if (exp_req_ok) begin
        chk("req_addr", mem_req_addr, exp_addr);
        chk("req_wen", mem_req_wen, exp_wen);
        chk("req_wdata", mem_req_wdata, exp_wdata);
        chk("req_wmask", mem_req_wmask, exp_wmask);
        obs_addr = mem_req_addr; obs_wdata = mem_req_wdata; obs_wmask = mem_req_wmask;
      end
      if (exp_out_on) begin
        chk("out_rdata", out_rdata, exp_rdata);
        chk("out_err", out_err, exp_err);
        obs_rdata = out_rdata; obs_err = out_err;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input bit ren, input bit wen, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [2:0] ctl, input int req_dly, input int resp_dly, input bit berr,
                         input logic [63:0] rdata, input int ordy_dly);
    int dw, nb, sb, off, t_exp;
    bit bad, noop, direct, store, tmo;
    logic [63:0] fm, dmask, v;
    dw = sel64 ? 64 : 32;
    nb = dw / 8;
    sb = 1 << ctl[1:0];
    off = int'(addr[2:0]) % nb;
    fm = (sb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sb)) - 64'd1);
    dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    bad = (sb == 8 && dw == 32) || (off % sb != 0);
    noop = !ren && !wen;
    direct = bad || noop;
    store = wen;
    tmo = !direct && (req_dly >= TMO || (resp_dly >= 1 && req_dly + resp_dly >= TMO - 1));
    t_exp = direct ? 1 : tmo ? TMO + 1 : req_dly + resp_dly + 3;
    v = ((rdata & dmask) >> (8 * off)) & fm;
    if (!ctl[2] && v[8 * sb - 1]) v = v | ~fm;
    v = v & dmask;
    exp_addr  = addr - 32'(off);
    exp_wen   = store;
    exp_wmask = store ? 8'(((1 << sb) - 1) << off) : 8'd0;
    exp_wdata = store ? (((wdata & fm) << (8 * off)) & dmask) : 64'd0;
    exp_err   = bad ? 2'd1 : noop ? 2'd0 : tmo ? 2'd3 : berr ? 2'd2 : 2'd0;
    exp_rdata = (!direct && !tmo && !berr && !store) ? v : 64'd0;

    in_valid = 1; in_ren = ren; in_wen = wen; in_addr = addr; in_wdata = wdata; in_ctl = ctl;
    chk("accept_ready", in_ready, 1);
    step();
    in_valid = 0; in_ren = 0; in_wen = 0; in_addr = 0; in_wdata = 0; in_ctl = 0;
    for (int t = 1; t <= t_exp; t++) begin
      exp_idle       = 0;
      exp_req_ok     = !direct && t <= req_dly + 1 && t <= TMO;
      exp_rr         = !direct && t > req_dly + 1 && t < t_exp;
      exp_out_on     = (t == t_exp);
      mem_req_ready  = !direct && (t == req_dly + 1);
      mem_resp_valid = !direct && t < t_exp && (t >= req_dly + 2 + resp_dly);
      mem_resp_rdata = rdata;
      mem_resp_err   = berr;
      if (t < t_exp) step();
    end
    for (int k = 0; k < ordy_dly; k++) step();
    out_ready = 1;
    step();
    out_ready = 0;
    exp_out_on = 0; exp_req_ok = 0; exp_idle = 1; exp_rr = 1;
  endtask

  task automatic rand_txn();
    bit ren, wen, be;
    int r, rd, sd, od;
    logic [31:0] addr, amask;
    logic [2:0] ctl;
    r = $urandom_range(0, 7);
    ren = (r >= 1 && r <= 4) || r == 7;
    wen = (r >= 5);
    ctl = 3'($urandom);
    addr = $urandom;
    amask = (32'd1 << ctl[1:0]) - 32'd1;
    if ($urandom_range(0, 3) != 0) addr = addr & ~amask;
    rd = $urandom_range(0, 4);
    sd = $urandom_range(0, 4);
    if ($urandom_range(0, 15) == 0) rd = 100;
    be = ($urandom_range(0, 7) == 0);
    od = $urandom_range(0, 2);
    run_txn(ren, wen, addr, {$urandom, $urandom}, ctl, rd, sd, be, {$urandom, $urandom}, od);
  endtask

  initial begin
    rst = 0; sel64 = 0;
    in_valid = 0; in_ren = 0; in_wen = 0; in_addr = 0; in_wdata = 0; in_ctl = 0;
    out_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0; mem_resp_rdata = 0;
    repeat (3) step();
    chk("reset_ctl", {in_ready, mem_resp_ready, out_valid, mem_req_valid}, 4'b1100);
    chk("reset_zero", |{out_rdata, out_err, mem_req_addr, mem_req_wdata, mem_req_wmask}, 0);
    rst = 1;
    mon_en = 1;

    run_txn(1, 0, 32'h8000_0003, 64'd0, 3'b000, 0, 0, 0, 64'h80FF_1234, 0);
    chk("lb_addr", obs_addr, 32'h8000_0000);
    chk("lb_wmask", obs_wmask, 8'h00);
    chk("lb_rdata", obs_rdata, 64'hFFFF_FF80);
    chk("lb_err", obs_err, 2'b00);
    run_txn(1, 0, 32'h8000_0003, 64'd0, 3'b100, 0, 0, 0, 64'h80FF_1234, 0);
    chk("lbu_rdata", obs_rdata, 64'h0000_0080);

    run_txn(0, 1, 32'h8000_0002, 64'h0000_ABCD, 3'b001, 5, 0, 0, 64'd0, 0);
    chk("sh_wmask", obs_wmask, 8'b1100);
    chk("sh_wdata", obs_wdata, 64'hABCD_0000);

    run_txn(1, 0, 32'h8000_0001, 64'd0, 3'b010, 0, 0, 0, 64'd0, 1);
    chk("misal_err", obs_err, 2'b01);
    run_txn(1, 0, 32'h8000_0000, 64'd0, 3'b011, 0, 0, 0, 64'd0, 0);
    chk("size_d_err", obs_err, 2'b01);

    run_txn(1, 0, 32'h8000_0008, 64'd0, 3'b010, 1, 1, 1, 64'h1234_5678, 3);
    chk("bus_err", obs_err, 2'b10);
    chk("bus_rdata", obs_rdata, 64'd0);

    run_txn(1, 0, 32'h8000_0010, 64'd0, 3'b010, 100, 0, 0, 64'd0, 0);
    chk("tmo_err", obs_err, 2'b11);
    mem_resp_valid = 1; mem_resp_rdata = 64'hDEAD_BEEF;
    repeat (2) step();
    mem_resp_valid = 0;
    step();
    run_txn(1, 0, 32'h8000_0004, 64'd0, 3'b010, 0, 0, 0, 64'h1234_5678, 0);
    chk("post_tmo_rdata", obs_rdata, 64'h1234_5678);

    for (int i = 0; i < 150; i++) rand_txn();

    sel64 = 1;
    step();
    run_txn(1, 0, 32'h0000_0010, 64'd0, 3'b011, 0, 0, 0, 64'hFEDC_BA98_7654_3210, 0);
    chk("ld64_rdata", obs_rdata, 64'hFEDC_BA98_7654_3210);
    chk("ld64_addr", obs_addr, 32'h0000_0010);

    mon_en = 0;
    in_valid = 1; in_ren = 1; in_addr = 32'h18; in_ctl = 3'b011;
    step();
    in_valid = 0; in_ren = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("in_resp", {in_ready, mem_resp_ready, mem_req_valid, out_valid}, 4'b0100);
    rst = 0;
    step();
    chk("rst_ctl", {in_ready, mem_resp_ready, mem_req_valid, out_valid}, 4'b1100);
    chk("rst_zero", |{out_rdata, out_err, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask}, 0);
    rst = 1;
    step();
    mon_en = 1;

    for (int i = 0; i < 100; i++) rand_txn();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
